dcm_lock_sequencer: RTL and testbench

- Sequences the DCM reset and lock handshake for the FPGA clock tree.
- Pulses dcm_reset for a fixed time, then waits for DCM LOCKED, with a timeout and bounded retries.
- Holds the core's synchronous reset until lock has been stable for a fixed time.
- Sits beside fpga_clocks, clocked from the buffered 50 MHz system clock. Drives fpga_clocks.dcm_reset and the CPU/core reset.

---
 rtl/dcm_lock_sequencer_if.sv | 19 +
 rtl/dcm_lock_sequencer.sv | 75 +++++++
 tb/tb_dcm_lock_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dcm_lock_sequencer_if.sv
// dcm_lock_sequencer_if: DCM lock handshake, core reset and debug status between sequencer and clock tree.
interface dcm_lock_sequencer_if;
  logic       dcm_locked;
  logic       dcm_reset;
  logic       sys_reset;
  logic       locked_ok;
  logic       failed;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  logic [2:0] state;
  modport master (
    input  dcm_locked,
    output dcm_reset, sys_reset, locked_ok, failed, retry_count, lock_loss_count, state
  );
  modport slave (
    output dcm_locked,
    input  dcm_reset, sys_reset, locked_ok, failed, retry_count, lock_loss_count, state
  );
endinterface

// File: rtl/dcm_lock_sequencer.sv
// dcm_lock_sequencer: pulses DCM reset, waits for lock with timeout/retries, and holds core reset until lock is stable.
module dcm_lock_sequencer #(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int HOLD_CYCLES  = 1024,
  parameter int MAX_RETRIES  = 15,
  parameter int CNT_W        = 20
) (
  input  logic               sysclk,
  input  logic               reset_n,
  dcm_lock_sequencer_if.master bus
);
  typedef enum logic [2:0] {RESET = 3'd0, WAIT_LOCK = 3'd1, HOLD = 3'd2, RUN = 3'd3, FAIL = 3'd4} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  logic s1, lk, timeout;
  logic [3:0] retry, retry_d;
  logic [7:0] loss, loss_d;
  logic dcm_rst_q, sys_rst_q, ok_q, fail_q;
  logic dcm_rst_d, sys_rst_d, ok_d, fail_d;
  assign timeout = cnt == CNT_W'(LOCK_TIMEOUT - 1);
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      st        <= RESET;
      cnt       <= '0;
      s1        <= 1'b0;
      lk        <= 1'b0;
      retry     <= '0;
      loss      <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ok_q      <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      s1        <= bus.dcm_locked;
      lk        <= s1;
      st        <= nxt;
      cnt       <= (nxt != st) ? '0 : cnt + CNT_W'(1);
      retry     <= retry_d;
      loss      <= loss_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      ok_q      <= ok_d;
      fail_q    <= fail_d;
    end
  // lock is checked before timeout so a coincident lock never costs a retry
  always_comb begin
    nxt = RESET;
    case (st)
      RESET:     nxt = (cnt == CNT_W'(RST_CYCLES - 1)) ? WAIT_LOCK : RESET;
      WAIT_LOCK: nxt = lk ? HOLD : !timeout ? WAIT_LOCK :
                       (retry + 4'd1 == 4'(MAX_RETRIES)) ? FAIL : RESET;
      HOLD:      nxt = !lk ? RESET : (cnt == CNT_W'(HOLD_CYCLES - 1)) ? RUN : HOLD;
      RUN:       nxt = lk ? RUN : RESET;
      FAIL:      nxt = FAIL;
      default:   nxt = RESET;
    endcase
  end
  always_comb begin
    dcm_rst_d = nxt == RESET;
    sys_rst_d = nxt != RUN;
    ok_d      = nxt == RUN;
    fail_d    = nxt == FAIL;
    retry_d   = (nxt == RUN) ? 4'd0 :
                (st == WAIT_LOCK && !lk && timeout) ? retry + 4'd1 : retry;
    loss_d    = ((st == HOLD || st == RUN) && !lk && loss != 8'hff) ? loss + 8'd1 : loss;
  end
  assign bus.dcm_reset       = dcm_rst_q;
  assign bus.sys_reset       = sys_rst_q;
  assign bus.locked_ok       = ok_q;
  assign bus.failed          = fail_q;
  assign bus.retry_count     = retry;
  assign bus.lock_loss_count = loss;
  assign bus.state           = st;
endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// tb_dcm_lock_sequencer: directed vectors for lock, timeout/retry, lock loss, flicker and async reset.
module tb_dcm_lock_sequencer;
  logic sysclk = 1'b0;
  logic reset_n = 1'b1;
  int tests = 0;
  int fails = 0;
  int ecount = 0;
  logic sr_fell = 1'b0;
  dcm_lock_sequencer_if bus();
  dcm_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(16), .HOLD_CYCLES(8), .MAX_RETRIES(3), .CNT_W(20)
  ) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 sysclk = ~sysclk;
  typedef struct {
    logic       lock;
    int         n;
    logic [2:0] st;
    logic       dr, sr, ok, fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } vec_t;
  vec_t vecs[15];
  function automatic logic [18:0] outs();
    return {bus.state, bus.dcm_reset, bus.sys_reset, bus.locked_ok, bus.failed,
            bus.retry_count, bus.lock_loss_count};
  endfunction
  function automatic logic [18:0] eo(logic [2:0] s, logic dr, logic sr, logic ok, logic fl,
                                     logic [3:0] rc, logic [7:0] lc);
    return {s, dr, sr, ok, fl, rc, lc};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge sysclk);
    #1;
    ecount++;
    if (!bus.sys_reset) sr_fell = 1'b1;
  endtask
  task automatic run_to(input int k);
    while (ecount < k) tick();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus.dcm_locked = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    ecount = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    vecs[0]  = '{1'b0, 3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[1]  = '{1'b0, 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[2]  = '{1'b0, 6, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[3]  = '{1'b1, 2, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[4]  = '{1'b1, 1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[5]  = '{1'b1, 7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vecs[6]  = '{1'b1, 1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    vecs[7]  = '{1'b0, 2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
    vecs[8]  = '{1'b0, 1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[9]  = '{1'b0, 2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[10] = '{1'b1, 1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[11] = '{1'b1, 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[12] = '{1'b1, 1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[13] = '{1'b1, 7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1};
    vecs[14] = '{1'b1, 1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd1};
    bus.dcm_locked = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk("reset_state", outs(), eo(3'd0, 1, 1, 0, 0, 4'd0, 8'd0));
    // nominal lock followed by a lock loss in RUN and recovery
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.dcm_locked = vecs[i].lock;
      for (int j = 0; j < vecs[i].n; j++) tick();
      chk($sformatf("vec%0d", i), outs(),
          eo(vecs[i].st, vecs[i].dr, vecs[i].sr, vecs[i].ok, vecs[i].fl, vecs[i].rc, vecs[i].lc));
    end
    // repeated timeouts into FAIL
    do_reset();
    run_to(19); chk("to_wait_last", outs(), eo(3'd1, 0, 1, 0, 0, 4'd0, 8'd0));
    run_to(20); chk("to_retry1",    outs(), eo(3'd0, 1, 1, 0, 0, 4'd1, 8'd0));
    run_to(23); chk("to_rst_hold",  outs(), eo(3'd0, 1, 1, 0, 0, 4'd1, 8'd0));
    run_to(24); chk("to_rst_end",   outs(), eo(3'd1, 0, 1, 0, 0, 4'd1, 8'd0));
    run_to(40); chk("to_retry2",    outs(), eo(3'd0, 1, 1, 0, 0, 4'd2, 8'd0));
    run_to(59); chk("to_wait3",     outs(), eo(3'd1, 0, 1, 0, 0, 4'd2, 8'd0));
    run_to(60); chk("to_fail",      outs(), eo(3'd4, 0, 1, 0, 1, 4'd3, 8'd0));
    bus.dcm_locked = 1'b1;
    run_to(70); chk("fail_sticky",  outs(), eo(3'd4, 0, 1, 0, 1, 4'd3, 8'd0));
    // lock coincident with timeout, then flicker in HOLD, then async reset mid-HOLD
    do_reset();
    run_to(20); chk("sim_retry1",   outs(), eo(3'd0, 1, 1, 0, 0, 4'd1, 8'd0));
    run_to(37);
    bus.dcm_locked = 1'b1;
    sr_fell = 1'b0;
    run_to(39); chk("sim_pre",      outs(), eo(3'd1, 0, 1, 0, 0, 4'd1, 8'd0));
    run_to(40); chk("sim_hold",     outs(), eo(3'd2, 0, 1, 0, 0, 4'd1, 8'd0));
    run_to(45);
    bus.dcm_locked = 1'b0;
    run_to(47); chk("flk_still",    outs(), eo(3'd2, 0, 1, 0, 0, 4'd1, 8'd0));
    run_to(48); chk("flk_reset",    outs(), eo(3'd0, 1, 1, 0, 0, 4'd1, 8'd1));
    bus.dcm_locked = 1'b1;
    run_to(52); chk("flk_wait",     outs(), eo(3'd1, 0, 1, 0, 0, 4'd1, 8'd1));
    run_to(53); chk("flk_hold",     outs(), eo(3'd2, 0, 1, 0, 0, 4'd1, 8'd1));
    chk("flk_sr_held", {31'd0, sr_fell}, 32'd0);
    run_to(55); chk("ar_pre",       outs(), eo(3'd2, 0, 1, 0, 0, 4'd1, 8'd1));
    reset_n = 1'b0;
    #1 chk("ar_async",              outs(), eo(3'd0, 1, 1, 0, 0, 4'd0, 8'd0));
    #3 reset_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
